// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction-fetch line server.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        REQ_FLUSHED = 2'd2
    } ifetch_state_e;

    function automatic int unsigned line_bytes(input int unsigned linewidth);
        return linewidth / 32'd8;
    endfunction

    // Clears the byte-offset bits below one line; lbytes must be a power of two.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned lbytes);
        return addr & ~(64'(lbytes) - 64'd1);
    endfunction

endpackage

// File: rtl/ifetch_outst_checker.sv
// Invariant monitor for the outstanding/drop counters.
module ifetch_outst_checker #(
    parameter int unsigned CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] outst_cnt_i,
    input logic [CW-1:0] drop_cnt_i
);

    a_drop_le_outst: assert property (@(posedge clk) disable iff (!rst) drop_cnt_i <= outst_cnt_i);

endmodule

// File: rtl/ifetch_outst_tracker.sv
// Counts granted reads awaiting response and how many of them must be discarded after a flush.
module ifetch_outst_tracker
    import ifu_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    localparam int unsigned CW = $clog2(MAX_OUTST + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    input  logic drop_inc_i,
    input  logic flush_i,
    output logic has_credit_o,
    output logic drop_now_o
);

    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          drop_pend_s;

    assign drop_pend_s  = (drop_q != {CW{1'b0}});
    assign has_credit_o = (outst_q < CW'(MAX_OUTST));
    // A response arriving in the flush cycle belongs to the old stream as well.
    assign drop_now_o   = dec_i & (drop_pend_s | flush_i);

    // Next-state for both counters; a flush reloads drop with everything still in flight.
    always_comb begin
        outst_d = outst_q + CW'(inc_i) - CW'(dec_i);
        if (flush_i) begin
            drop_d = outst_q + CW'(inc_i) - CW'(dec_i);
        end else if (dec_i && drop_pend_s) begin
            drop_d = drop_q + CW'(drop_inc_i) - CW'(1'b1);
        end else begin
            drop_d = drop_q + CW'(drop_inc_i);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outst_q <= {CW{1'b0}};
            drop_q  <= {CW{1'b0}};
        end else begin
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    ifetch_outst_checker #(.CW(CW)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .outst_cnt_i (outst_q),
        .drop_cnt_i  (drop_q)
    );

endmodule

// File: rtl/ifetch_line_server.sv
// Memory-side line refill responder: sequential fetch, redirect on flush, in-order line return.
// Define IFETCH_RESP_BUF_EN to register line_valid/line_out (one extra cycle of latency).
module ifetch_line_server
    import ifu_pkg::*;
#(
    parameter int unsigned     LINEWIDTH = 64,
    parameter int unsigned     ADDRW     = 32,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [ADDRW-1:0] RESET_PC = {ADDRW{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ADDRW-1:0]     redirect_pc,
    input  logic                 ld_line,
    output logic                 line_ready,
    output logic                 line_valid,
    output logic [LINEWIDTH-1:0] line_out,
    output logic [1:0]           order_when_flush_rdptr,
    output logic [1:0]           order_when_flush_nextcnt,
    output logic                 mem_req,
    output logic [ADDRW-1:0]     mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [LINEWIDTH-1:0] mem_rdata
);

    localparam int unsigned      LINE_BYTES    = line_bytes(LINEWIDTH);
    localparam logic [ADDRW-1:0] LINE_INC      = ADDRW'(LINE_BYTES);
    localparam logic [ADDRW-1:0] RESET_ALIGNED = ADDRW'(line_align(64'(RESET_PC), LINE_BYTES));

    ifetch_state_e    state_q, state_d;
    logic [ADDRW-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]       order_q, order_d;
    logic [ADDRW-1:0] redirect_aligned_s;
    logic             grant_s, drop_inc_s, has_credit_s, drop_now_s, resp_ok_s;

    assign redirect_aligned_s = ADDRW'(line_align(64'(redirect_pc), LINE_BYTES));

    // FSM next state, request channel and fetch-address/redirect bookkeeping.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        mem_addr_d   = mem_addr_q;
        order_d      = order_q;
        line_ready   = 1'b0;
        mem_req      = 1'b0;
        grant_s      = 1'b0;
        drop_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                line_ready = rst & ~flush & has_credit_s;
                if (ld_line && line_ready) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_addr_q;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    grant_s      = 1'b1;
                    state_d      = IDLE;
                    fetch_addr_d = fetch_addr_q + LINE_INC;
                end else if (flush) begin
                    state_d = REQ_FLUSHED;
                end else begin
                    state_d = REQ;
                end
            end
            // Address stays on the bus until granted; the data it returns is stale.
            REQ_FLUSHED: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    grant_s    = 1'b1;
                    drop_inc_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = REQ_FLUSHED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            fetch_addr_d = redirect_aligned_s;
            order_d      = redirect_pc[2:1];
        end else begin
            order_d = order_q;
        end
    end

    // State and address registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= RESET_ALIGNED;
            mem_addr_q   <= RESET_ALIGNED;
            order_q      <= RESET_PC[2:1];
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            order_q      <= order_d;
        end
    end

    ifetch_outst_tracker #(.MAX_OUTST(MAX_OUTST)) u_trk (
        .clk          (clk),
        .rst          (rst),
        .inc_i        (grant_s),
        .dec_i        (mem_rvalid),
        .drop_inc_i   (drop_inc_s),
        .flush_i      (flush),
        .has_credit_o (has_credit_s),
        .drop_now_o   (drop_now_s)
    );

    assign resp_ok_s                = mem_rvalid & ~drop_now_s & ~flush;
    assign mem_addr                 = mem_addr_q;
    assign order_when_flush_rdptr   = order_q;
    assign order_when_flush_nextcnt = order_q;

`ifdef IFETCH_RESP_BUF_EN
    logic                 line_valid_q;
    logic [LINEWIDTH-1:0] line_out_q;

    // Response register; line data holds between valid pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_valid_q <= 1'b0;
            line_out_q   <= {LINEWIDTH{1'b0}};
        end else begin
            line_valid_q <= resp_ok_s;
            if (resp_ok_s) begin
                line_out_q <= mem_rdata;
            end
        end
    end

    assign line_valid = line_valid_q;
    assign line_out   = line_out_q;
`else
    assign line_valid = resp_ok_s;
    assign line_out   = mem_rdata;
`endif

endmodule

// File: tb/tb_ifetch_line_server.sv
// Scoreboard bench for ifetch_line_server with a cycle-stepped memory model.
module tb_ifetch_line_server;

    localparam int          MO  = 2;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk, rst, flush, ld_line, line_ready, line_valid;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] redirect_pc, mem_addr;
    logic [63:0] line_out, mem_rdata;
    logic [1:0]  ord_rd, ord_nc;

    ifetch_line_server #(
        .LINEWIDTH (64),
        .ADDRW     (32),
        .MAX_OUTST (MO),
        .RESET_PC  (RPC)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .flush                    (flush),
        .redirect_pc              (redirect_pc),
        .ld_line                  (ld_line),
        .line_ready               (line_ready),
        .line_valid               (line_valid),
        .line_out                 (line_out),
        .order_when_flush_rdptr   (ord_rd),
        .order_when_flush_nextcnt (ord_nc),
        .mem_req                  (mem_req),
        .mem_addr                 (mem_addr),
        .mem_gnt                  (mem_gnt),
        .mem_rvalid               (mem_rvalid),
        .mem_rdata                (mem_rdata)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
        bit          drop;
    } rsp_t;

    rsp_t        pipe[$];
    logic [31:0] glog[$];
    int          n_cmp, n_bad, cyc, lat, gnt_hold, lv_count, last_rv_cyc, last_rise_cyc, m_outst;
    bit          m_pend, m_pend_fl, prev_ready, arm_frg, frg_hit, want_first;
    logic [31:0] arm_pc, m_fetch, m_req_addr;
    logic [1:0]  m_order;
    logic [63:0] first_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required $finish before 500us");
        $fatal(1);
    end

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {~a, a ^ 32'h5a5a_0000};
    endfunction

    // Reference model: checks this cycle's outputs, then advances the model state.
    task automatic check_cycle();
        bit   exp_ready, gnt_now, exp_lv;
        rsp_t e, n;
        if (!rst) begin
            n_cmp++;
            if (line_ready !== 1'b0 || line_valid !== 1'b0 || line_out !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: ready=%b valid=%b out=%h, required 0 0 0", line_ready, line_valid, line_out);
            end
            pipe.delete();
            m_pend = 1'b0; m_pend_fl = 1'b0; m_outst = 0; m_fetch = RPC; m_order = 2'b00; prev_ready = 1'b0;
        end else begin
            exp_ready = !flush && !m_pend && (m_outst < MO);
            n_cmp++;
            if (line_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL line_ready c%0d: got %b, required %b", cyc, line_ready, exp_ready);
            end
            n_cmp++;
            if (mem_req !== m_pend) begin
                n_bad++;
                $display("FAIL mem_req c%0d: got %b, required %b", cyc, mem_req, m_pend);
            end
            if (m_pend) begin
                n_cmp++;
                if (mem_addr !== m_req_addr) begin
                    n_bad++;
                    $display("FAIL mem_addr c%0d: got %h, required %h", cyc, mem_addr, m_req_addr);
                end
            end
            n_cmp++;
            if (ord_rd !== m_order || ord_nc !== m_order) begin
                n_bad++;
                $display("FAIL order c%0d: got %0d/%0d, required %0d", cyc, ord_rd, ord_nc, m_order);
            end
            gnt_now = m_pend && mem_gnt;
            exp_lv  = 1'b0;
            if (mem_rvalid) begin
                e = pipe.pop_front();
                exp_lv = !e.drop && !flush;
                last_rv_cyc = cyc;
            end
            n_cmp++;
            if (line_valid !== exp_lv) begin
                n_bad++;
                $display("FAIL line_valid c%0d: got %b, required %b", cyc, line_valid, exp_lv);
            end
            if (exp_lv) begin
                n_cmp++;
                if (line_out !== e.data) begin
                    n_bad++;
                    $display("FAIL line_out c%0d: got %h, required %h", cyc, line_out, e.data);
                end
                if (want_first) begin
                    first_line = line_out;
                    want_first = 1'b0;
                end
                lv_count++;
            end
            if (line_ready && !prev_ready) last_rise_cyc = cyc;
            prev_ready = line_ready;
            if (gnt_now) begin
                glog.push_back(mem_addr);
                n.due = cyc + lat; n.data = pat(m_req_addr); n.drop = m_pend_fl || flush;
                pipe.push_back(n);
            end
            if (flush) begin
                foreach (pipe[i]) pipe[i].drop = 1'b1;
            end
            m_outst = m_outst + int'(gnt_now) - int'(mem_rvalid);
            if (flush) begin
                m_fetch = {redirect_pc[31:3], 3'b000};
                m_order = redirect_pc[2:1];
            end else if (gnt_now && !m_pend_fl) begin
                m_fetch = m_fetch + 32'd8;
            end
            if (gnt_now) begin
                m_pend = 1'b0; m_pend_fl = 1'b0;
            end else if (flush && m_pend) begin
                m_pend_fl = 1'b1;
            end
            if (ld_line && exp_ready) begin
                m_pend = 1'b1; m_pend_fl = 1'b0; m_req_addr = m_fetch;
            end
        end
    endtask

    // One clock cycle: drive memory, sample at the falling edge, advance past the rising edge.
    task automatic tick();
        if (rst && m_pend) begin
            if (gnt_hold > 0) begin
                mem_gnt = 1'b0;
                gnt_hold--;
            end else begin
                mem_gnt = 1'b1;
            end
        end else begin
            mem_gnt = 1'b0;
        end
        if (rst && pipe.size() > 0 && pipe[0].due <= cyc) begin
            mem_rvalid = 1'b1; mem_rdata = pipe[0].data;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = 64'd0;
        end
        if (arm_frg && mem_gnt && mem_rvalid) begin
            flush = 1'b1; redirect_pc = arm_pc; arm_frg = 1'b0; frg_hit = 1'b1;
        end
        #4;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        flush = 1'b0;
    endtask

    task automatic wait_outst2(input string name);
        for (int i = 0; i < 20 && m_outst < 2; i++) tick();
        n_cmp++;
        if (m_outst != 2) begin
            n_bad++;
            $display("FAIL %s_timeout: outstanding %0d, required 2", name, m_outst);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ld_line = 1'b0;
        tick(); tick();
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h100 || ord_rd !== 2'd0 || ord_nc !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: req=%b addr=%h ord=%0d/%0d, required 0 100 0/0", mem_req, mem_addr, ord_rd, ord_nc);
        end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        int lv0;
        lat = 1; gnt_hold = 0; glog.delete(); lv0 = lv_count;
        ld_line = 1'b1;
        repeat (12) tick();
        ld_line = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (glog.size() != 6) begin
            n_bad++;
            $display("FAIL seq_throughput: got %0d grants, required 6", glog.size());
        end else begin
            n_cmp++;
            if (glog[0] !== 32'h100 || glog[1] !== 32'h108 || glog[2] !== 32'h110) begin
                n_bad++;
                $display("FAIL seq_addrs: got %h %h %h, required 100 108 110", glog[0], glog[1], glog[2]);
            end
        end
        n_cmp++;
        if (lv_count - lv0 != 6) begin
            n_bad++;
            $display("FAIL seq_lines: got %0d lines, required 6", lv_count - lv0);
        end
    endtask

    task automatic test_credit();
        int rise0;
        lat = 6; ld_line = 1'b1;
        wait_outst2("credit");
        n_cmp++;
        if (line_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL credit_block: got line_ready %b, required 0", line_ready);
        end
        rise0 = last_rise_cyc;
        for (int i = 0; i < 20 && last_rise_cyc == rise0; i++) tick();
        n_cmp++;
        if (last_rise_cyc != last_rv_cyc + 1) begin
            n_bad++;
            $display("FAIL credit_rise: rise at c%0d, required c%0d", last_rise_cyc, last_rv_cyc + 1);
        end
        ld_line = 1'b0;
        repeat (16) tick();
    endtask

    task automatic test_flush_outstanding();
        int lv0;
        lat = 4; ld_line = 1'b1;
        wait_outst2("flush_out");
        ld_line = 1'b0; flush = 1'b1; redirect_pc = 32'h2006; lv0 = lv_count;
        tick();
        n_cmp++;
        if (ord_rd !== 2'd3 || ord_nc !== 2'd3) begin
            n_bad++;
            $display("FAIL flush_order: got %0d/%0d, required 3", ord_rd, ord_nc);
        end
        repeat (8) tick();
        n_cmp++;
        if (lv_count != lv0) begin
            n_bad++;
            $display("FAIL flush_drop: got %0d lines, required 0", lv_count - lv0);
        end
        glog.delete(); want_first = 1'b1; lat = 1;
        ld_line = 1'b1; tick(); ld_line = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (glog.size() < 1 || glog[0] !== 32'h2000 || first_line !== pat(32'h2000)) begin
            n_bad++;
            $display("FAIL flush_redirect: got %h, required %h", first_line, pat(32'h2000));
        end
    endtask

    task automatic test_gnt_withheld();
        int lv0;
        lat = 1; gnt_hold = 5; glog.delete(); lv0 = lv_count;
        ld_line = 1'b1; tick(); ld_line = 1'b0;
        tick();
        flush = 1'b1; redirect_pc = 32'h3000;
        repeat (8) tick();
        n_cmp++;
        if (glog.size() != 1 || lv_count != lv0) begin
            n_bad++;
            $display("FAIL withheld_drop: got %0d grants %0d lines, required 1 0", glog.size(), lv_count - lv0);
        end
        ld_line = 1'b1; tick(); ld_line = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (glog.size() != 2 || glog[glog.size()-1] !== 32'h3000) begin
            n_bad++;
            $display("FAIL withheld_next: got %0d grants, required 2 with last at 3000", glog.size());
        end
    endtask

    task automatic test_flush_rv_gnt();
        lat = 2; arm_frg = 1'b1; arm_pc = 32'h4000; frg_hit = 1'b0;
        ld_line = 1'b1;
        for (int i = 0; i < 20 && !frg_hit; i++) tick();
        ld_line = 1'b0;
        n_cmp++;
        if (!frg_hit || dut.u_trk.drop_q !== 2'd1 || dut.u_trk.outst_q !== 2'd1) begin
            n_bad++;
            $display("FAIL frg_counts: hit=%b drop=%0d outst=%0d, required 1 1 1", frg_hit, dut.u_trk.drop_q, dut.u_trk.outst_q);
        end
        want_first = 1'b1;
        ld_line = 1'b1; tick(); ld_line = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (first_line !== pat(32'h4000)) begin
            n_bad++;
            $display("FAIL frg_next_line: got %h, required %h", first_line, pat(32'h4000));
        end
    endtask

    task automatic test_reset_mid();
        lat = 1; gnt_hold = 3;
        ld_line = 1'b1; tick(); ld_line = 1'b0;
        tick();
        rst = 1'b0; tick(); rst = 1'b1;
        gnt_hold = 0;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h100 || dut.u_trk.outst_q !== 2'd0 || dut.u_trk.drop_q !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_mid: req=%b addr=%h outst=%0d drop=%0d, required 0 100 0 0", mem_req, mem_addr, dut.u_trk.outst_q, dut.u_trk.drop_q);
        end
        glog.delete();
        ld_line = 1'b1; tick(); ld_line = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (glog.size() != 1 || glog[0] !== 32'h100) begin
            n_bad++;
            $display("FAIL reset_mid_restart: got %0d grants, required 1 at 100", glog.size());
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; gnt_hold = 0; lv_count = 0;
        last_rv_cyc = 0; last_rise_cyc = 0; m_outst = 0;
        m_pend = 1'b0; m_pend_fl = 1'b0; prev_ready = 1'b0; arm_frg = 1'b0; frg_hit = 1'b0; want_first = 1'b0;
        arm_pc = 32'd0; m_fetch = RPC; m_req_addr = 32'd0; m_order = 2'b00; first_line = 64'd0;
        rst = 1'b0; flush = 1'b0; ld_line = 1'b0; redirect_pc = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_credit();
        test_flush_outstanding();
        test_gnt_withheld();
        test_flush_rv_gnt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_line_server.md
# ifetch_line_server

Memory-side responder for the instruction line-refill protocol: accepts line requests (`ld_line`/`line_ready`) from the instruction buffer, issues aligned line reads to the instruction memory port, and returns lines in order (`line_valid`/`line_out`). It owns the sequential fetch address, applies redirects on `flush`, and discards responses to requests issued before a flush. It sits between the instruction buffer and the instruction SRAM/bus adapter in the fetch stage.

## Interface
- `LINEWIDTH`, 64: line width in bits; a multiple of 16.
- `ADDRW`, 32: address width.
- `MAX_OUTST`, 2: maximum number of granted memory reads awaiting response; at least 1.
- `RESET_PC`, 32'h0: fetch start address after reset.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `flush` in 1: pipeline redirect; `redirect_pc` is valid in the same cycle.
- `redirect_pc` in ADDRW: new fetch PC.
- `ld_line` in 1: line request from the instruction buffer.
- `line_ready` out 1: request accepted this cycle when high together with `ld_line`.
- `line_valid` out 1: one-cycle pulse; `line_out` is valid.
- `line_out` out LINEWIDTH: line data, halfword 0 in bits [15:0].
- `order_when_flush_rdptr` out 2: `redirect_pc[2:1]` of the last flush; the halfword start offset in the first line.
- `order_when_flush_nextcnt` out 2: same value; the number of halfwords skipped in the first line after a redirect.
- `mem_req` out 1, `mem_addr` out ADDRW, `mem_gnt` in 1: request channel. Once `mem_req` rises, it and `mem_addr` hold until `mem_gnt`.
- `mem_rvalid` in 1, `mem_rdata` in LINEWIDTH: in-order response, at least one cycle after grant.

## Operation
- `LINE_BYTES = LINEWIDTH/8`. `fetch_addr` is always line-aligned: its low `$clog2(LINE_BYTES)` bits are zero.
- **FSM states**
  - IDLE: `line_ready = rst & ~flush & (outst_cnt < MAX_OUTST)`. On `ld_line & line_ready`, go to REQ.
  - REQ: `mem_req = 1`, `mem_addr = fetch_addr`.
    - On `mem_gnt`: `fetch_addr += LINE_BYTES` (wraps mod 2^ADDRW), `outst_cnt++`, go to IDLE.
    - On `flush` without `mem_gnt`: go to REQ_FLUSHED.
  - REQ_FLUSHED: `mem_req` stays high with the old `mem_addr`. On `mem_gnt`: `outst_cnt++`, `drop_cnt++`, go to IDLE. `fetch_addr` is not incremented.
  - `line_ready` is 0 in REQ and REQ_FLUSHED.
- **Flush**
  - `fetch_addr <= redirect_pc` aligned; both `order_*` outputs `<= redirect_pc[2:1]`.
  - `drop_cnt <= outst_cnt - (mem_rvalid ? 1 : 0)`, plus 1 if in REQ and `mem_gnt` is high the same cycle. That request goes to IDLE and counts as dropped.
  - No `line_valid` is generated in the flush cycle.
- **Response**
  - `mem_rvalid` decrements `outst_cnt`.
  - If `drop_cnt > 0`, decrement it and suppress the line.
  - Otherwise present `mem_rdata` with `line_valid`.
- **Simultaneous events**
  - grant and rvalid in the same cycle: `outst_cnt` is unchanged.
  - flush and rvalid in the same cycle: that response is dropped.
- **Counter widths**: `outst_cnt` and `drop_cnt` are `$clog2(MAX_OUTST+1)` bits. `drop_cnt <= outst_cnt` is always true; assert it.
- **Reset mid-operation**: all state clears immediately. The memory adapter is reset on the same `rst`.

## Timing
- Reset values:
  - `line_ready` 0 (gated by `rst`), `line_valid` 0, `line_out` 0, `mem_req` 0.
  - `mem_addr` = aligned `RESET_PC`.
  - `order_*` = `RESET_PC[2:1]`.
- `ld_line` accepted in cycle N gives `mem_req` in N+1. With grant in N+1 and rvalid in N+2, `line_valid` is in N+2 (N+3 with the buffer).
- Sustained throughput is one line per 2 cycles per request slot. With `MAX_OUTST = 2` and 1-cycle memory, one line every 2 cycles.

## Configuration
- `IFETCH_RESP_BUF_EN` defined: `line_valid`/`line_out` come from a response register.
  - Adds one cycle of latency.
  - `flush` clears a pending registered line, so no `line_valid` in the next cycle.
  - `line_out` holds its last value when not valid.
- Undefined: `line_valid = mem_rvalid & (drop_cnt == 0) & ~flush` and `line_out = mem_rdata`, both combinational.

## Structure
- Package `ifu_pkg` holds:
  - `ifetch_state_e` (IDLE, REQ, REQ_FLUSHED);
  - the `LINE_BYTES` localparam function;
  - the `line_align()` function.
- Sub-module `ifetch_outst_tracker` holds `outst_cnt`/`drop_cnt` with increment/decrement/flush-load inputs and outputs `has_credit` and `drop_now`.

## Test plan
- Reset with `RESET_PC = 0x100`, `ld_line` held, 1-cycle memory → `mem_addr` sequence 0x100, 0x108, 0x110; data returned in order; `order_*` = 0.
- `flush` with `redirect_pc = 0x2006` while 2 reads are outstanding → both responses dropped; next `mem_addr` 0x2000; `order_*` = 3.
- `mem_gnt` withheld 5 cycles, `flush` in cycle 2 → `mem_req`/`mem_addr` stable throughout; that response dropped; next request uses the redirect address.
- `MAX_OUTST = 2`, rvalid delayed 6 cycles → `line_ready` falls after 2 grants and rises in the cycle `outst_cnt` drops to 1.
- `flush` coincident with `mem_rvalid` and `mem_gnt` → that response is dropped; `drop_cnt` = 1 afterwards; next valid line comes from the redirect address.
- Reset asserted mid-REQ → next cycle `mem_req` = 0, counters = 0, `mem_addr` = aligned `RESET_PC`.
